// File: rtl/mux_nx1_rr_if.sv
// mux_nx1_rr_if -- channel bundle for the N:1 round-robin gathering mux.
//   en      : 1 permits new grants, 0 blocks them
//   i       : N*W packed channel data, channel k at i[k*W +: W]
//   v       : per-channel valid
//   ack     : per-channel accept (combinational, one-hot or zero)
//   y       : registered selected data
//   s       : registered index of the channel held in y
//   y_valid : y/s hold a word not yet taken downstream
//   o_ready : downstream takes y/s when y_valid & o_ready
// The master modport is the side that feeds the channels and drains y.
// The slave modport is the mux itself.
interface mux_nx1_rr_if #(
  parameter int N = 4,
  parameter int W = 1
);
  localparam int SW = $clog2(N);

  logic           en;
  logic [N*W-1:0] i;
  logic [N-1:0]   v;
  logic [N-1:0]   ack;
  logic [W-1:0]   y;
  logic [SW-1:0]  s;
  logic           y_valid;
  logic           o_ready;

  modport master (
    output en, i, v, o_ready,
    input  ack, y, s, y_valid
  );

  modport slave (
    input  en, i, v, o_ready,
    output ack, y, s, y_valid
  );
endinterface

// File: rtl/mux_nx1_rr.sv
// mux_nx1_rr -- N:1 round-robin gathering mux with a one-word output register.
// The registered index s can drive the select of a downstream 1xN demux.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mux_nx1_rr_if slave modport (en, i, v, ack, y, s, y_valid, o_ready)
// The grant search starts at ptr and wraps modulo N. After each grant, ptr
// moves to the slot just past the winner, so each channel gets a fair turn.
module mux_nx1_rr #(
  parameter int N = 4,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  mux_nx1_rr_if.slave  bus
);
  localparam int SW = $clog2(N);

  logic [SW-1:0] ptr_reg, ptr_next;
  logic [SW-1:0] s_reg;
  logic [W-1:0]  y_reg;
  logic          y_valid_reg;

  logic [SW-1:0] grant;
  logic          found;
  logic          out_free;
  logic          take;
  logic [W-1:0]  grant_data;

  // Rotating priority search: visit ptr, ptr+1, ... wrapping at N. The
  // first valid channel on that walk wins.
  always_comb begin
    int idx;
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= N) idx = idx - N;
      if (!found && bus.v[idx]) begin
        found = 1'b1;
        grant = SW'(idx);
      end
    end
  end

  // The register can take a new word when it is empty, or when it is
  // draining in this same cycle. The draining case gives the no-bubble
  // replace. Gating with rst_n keeps ack low while reset is held, because
  // the cleared y_valid would otherwise make the register look free.
  assign out_free   = !y_valid_reg || bus.o_ready;
  assign take       = rst_n && bus.en && out_free && found;
  assign grant_data = bus.i[int'(grant)*W +: W];
  assign ptr_next   = (int'(grant) == N-1) ? '0 : grant + SW'(1);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ack
      assign bus.ack[gi] = take && (int'(grant) == gi);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg     <= '0;
      s_reg       <= '0;
      y_reg       <= '0;
      y_valid_reg <= 1'b0;
    end else if (take) begin
      y_reg       <= grant_data;
      s_reg       <= grant;
      y_valid_reg <= 1'b1;
      ptr_reg     <= ptr_next;
    end else if (y_valid_reg && bus.o_ready) begin
      // Accepted with nothing to replace it: y and s keep their last value.
      y_valid_reg <= 1'b0;
    end
  end

  assign bus.y       = y_reg;
  assign bus.s       = s_reg;
  assign bus.y_valid = y_valid_reg;
endmodule

// File: tb/tb_mux_nx1_rr.sv
// tb_mux_nx1_rr -- directed scenarios plus randomized traffic for
// mux_nx1_rr (N=4, W=1). Each cycle is checked against a reference model.
// The model picks the channel with the smallest forward distance from ptr.
module tb_mux_nx1_rr;
  localparam int N  = 4;
  localparam int W  = 1;
  localparam int SW = $clog2(N);

  logic clk;
  logic rst_n;

  mux_nx1_rr_if #(.N(N), .W(W)) bus ();

  mux_nx1_rr #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run;
  int tests_failed;

  // Reference state: the word the output register should hold.
  int         m_ptr;
  int         m_s;
  logic [W-1:0] m_y;
  logic       m_yv;
  logic [N-1:0] last_ack;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one cycle's inputs at the falling edge and checks the outputs
  // and ack just before the rising edge. Then it advances the model.
  task automatic run_cycle(input logic e, input logic [N-1:0] vv,
                           input logic [N*W-1:0] ii, input logic rdy, input string tag);
    int best_d;
    int g;
    int d;
    logic take;
    logic [N-1:0] exp_ack;
    @(negedge clk);
    bus.en      = e;
    bus.v       = vv;
    bus.i       = ii;
    bus.o_ready = rdy;
    #1;
    best_d = N;
    g      = 0;
    for (int k = 0; k < N; k++) begin
      d = (k - m_ptr + N) % N;
      if (vv[k] && d < best_d) begin
        best_d = d;
        g      = k;
      end
    end
    take    = e && (!m_yv || rdy) && (vv != '0);
    exp_ack = take ? N'(1 << g) : '0;
    last_ack = bus.ack;
    check({tag, ".ack"},     32'(bus.ack),     32'(exp_ack));
    check({tag, ".y"},       32'(bus.y),       32'(m_y));
    check({tag, ".s"},       32'(bus.s),       32'(m_s));
    check({tag, ".y_valid"}, 32'(bus.y_valid), 32'(m_yv));
    $display("[TB] %s en=%b v=%b i=%b rdy=%b ack=%b y=%b s=%0d yv=%b",
             tag, e, vv, ii, rdy, bus.ack, bus.y, bus.s, bus.y_valid);
    @(posedge clk);
    if (take) begin
      m_y   = ii[g*W +: W];
      m_s   = g;
      m_yv  = 1'b1;
      m_ptr = (g + 1) % N;
    end else if (m_yv && rdy) begin
      m_yv = 1'b0;
    end
  endtask

  // Pulses reset between rising edges and checks the immediate clear.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    bus.en = 1'b1;
    bus.v  = '1;
    bus.o_ready = 1'b0;
    rst_n  = 1'b0;
    #1;
    check({tag, ".y"},       32'(bus.y),       32'd0);
    check({tag, ".s"},       32'(bus.s),       32'd0);
    check({tag, ".y_valid"}, 32'(bus.y_valid), 32'd0);
    check({tag, ".ack"},     32'(bus.ack),     32'd0);
    $display("[TB] %s reset asserted y=%b s=%0d yv=%b ack=%b",
             tag, bus.y, bus.s, bus.y_valid, bus.ack);
    m_ptr = 0; m_s = 0; m_y = '0; m_yv = 1'b0;
    @(negedge clk);
    bus.v = '0;
    rst_n = 1'b1;
  endtask

  int exp_seq [5] = '{1, 2, 4, 8, 1};

  initial begin
    tests_run = 0;
    tests_failed = 0;
    m_ptr = 0; m_s = 0; m_y = '0; m_yv = 1'b0;
    last_ack = '0;
    rst_n = 1'b0;
    bus.en = 1'b0; bus.v = '0; bus.i = '0; bus.o_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.y",       32'(bus.y),       32'd0);
    check("reset.s",       32'(bus.s),       32'd0);
    check("reset.y_valid", 32'(bus.y_valid), 32'd0);
    check("reset.ack",     32'(bus.ack),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full round-robin rotation over all four channels.
    for (int c = 0; c < 5; c++) begin
      run_cycle(1'b1, 4'b1111, 4'b1010, 1'b1, "rotate");
      check("rotate.seq", 32'(last_ack), 32'(exp_seq[c]));
    end
    run_cycle(1'b1, 4'b0000, 4'b1010, 1'b1, "rotate.drain");

    // Grant channel 1 so ptr=2, then only 0/1 valid: must wrap to 0.
    run_cycle(1'b1, 4'b0010, 4'b0000, 1'b1, "set_ptr2");
    run_cycle(1'b1, 4'b0011, 4'b0001, 1'b1, "wrap");
    check("wrap.ack", 32'(last_ack), 32'd1);
    run_cycle(1'b1, 4'b0011, 4'b0000, 1'b1, "wrap.next");
    check("wrap.ptr1", 32'(last_ack), 32'd2);

    // Backpressure: hold while o_ready=0, then resume.
    repeat (3) begin
      run_cycle(1'b1, 4'b1111, 4'b0101, 1'b0, "stall");
      check("stall.noack", 32'(last_ack), 32'd0);
    end
    repeat (2) run_cycle(1'b1, 4'b1111, 4'b0101, 1'b1, "resume");

    // Grants blocked while the held word drains once.
    repeat (4) begin
      run_cycle(1'b0, 4'b1111, 4'b1111, 1'b1, "en_off");
      check("en_off.noack", 32'(last_ack), 32'd0);
    end

    // No requests: nothing granted, ptr stays put (checked on resume).
    repeat (5) run_cycle(1'b1, 4'b0000, 4'b1111, 1'b1, "idle");
    repeat (2) run_cycle(1'b1, 4'b1111, 4'b1100, 1'b1, "after_idle");

    // Reset mid-stream, then only channel 3 requests.
    run_cycle(1'b1, 4'b1111, 4'b1111, 1'b0, "pre_rst");
    pulse_reset("midrst");
    run_cycle(1'b1, 4'b1000, 4'b1000, 1'b1, "post_rst");
    check("post_rst.ack", 32'(last_ack), 32'd8);
    run_cycle(1'b1, 4'b0000, 4'b0000, 1'b1, "post_rst.s");

    // Randomized traffic.
    for (int c = 0; c < 300; c++) begin
      run_cycle(($urandom_range(0, 7) != 0), N'($urandom), (N*W)'($urandom),
                ($urandom_range(0, 3) != 0), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/mux_nx1_rr.md
MUX_NX1_RR -- requirements
Module: mux_nx1_rr

Interface
REQ-001 The parameter N SHALL default to 4 and set the number of input channels, with a legal range of 2..16.
REQ-002 The parameter W SHALL default to 1 and set the data width per channel.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low (clk, rst_n).
REQ-004 Port clk SHALL be an input, 1 bit wide, and act as the single rising-edge clock.
REQ-005 Port rst_n SHALL be an input, 1 bit wide, and act as the asynchronous active-low reset.
REQ-006 Port en SHALL be an input, 1 bit wide; 1 permits new grants and 0 blocks them.
REQ-007 Port i SHALL be an input, N*W bits wide; channel k data is i[k*W +: W].
REQ-008 Port v SHALL be an input, N bits wide; v[k] is the channel k valid.
REQ-009 Port ack SHALL be an output, N bits wide; ack[k] accepts channel k in the current cycle.
REQ-010 Port y SHALL be an output, W bits wide, carrying the registered selected data.
REQ-011 Port s SHALL be an output, $clog2(N) bits wide, carrying the registered index of the channel held in y.
REQ-012 Port y_valid SHALL be an output, 1 bit wide, and be 1 while y/s hold an unaccepted word.
REQ-013 Port o_ready SHALL be an input, 1 bit wide; downstream accepts y/s when y_valid and o_ready are both 1.

Function
REQ-014 The block SHALL be the N:1 gathering end of the 1xN demux path, so that s can drive a downstream demux select directly.
REQ-015 The output register SHALL be free when y_valid=0, or when y_valid=1 and o_ready=1 in the same cycle.
REQ-016 The grant SHALL be the first index k with v[k]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (modulo N).
REQ-017 ack[k] SHALL be combinational and equal 1 only when en=1, the output register is free, v[k]=1, and k is the grant.
REQ-018 At most one ack bit SHALL be 1 in any cycle.
REQ-019 On a clock edge where an ack bit is 1, y SHALL load i[grant], s SHALL load grant, y_valid SHALL become 1, and ptr SHALL become (grant+1) mod N.
REQ-020 Latency from ack to y_valid SHALL be exactly 1 cycle.
REQ-021 Back-to-back transfers SHALL sustain 1 word per cycle while o_ready=1.
REQ-022 On an edge where y is accepted (y_valid=1, o_ready=1) and no ack is issued, y_valid SHALL clear to 0 while y and s retain their values.
REQ-023 While y_valid=1 and o_ready=0, y, s and y_valid SHALL hold, all ack bits SHALL be 0, and ptr SHALL hold.
REQ-024 When en=0, all ack bits SHALL be 0 and ptr SHALL hold, while a held word SHALL still drain normally via o_ready.
REQ-025 When v=0, no grant SHALL occur and ptr SHALL hold.
REQ-026 When a grant is at index N-1, ptr SHALL wrap to 0.
REQ-027 When the only valid channel equals ptr-1, the search SHALL wrap and grant that channel.
REQ-028 Changes to i or v in cycles without an ack SHALL have no effect on the outputs.
REQ-029 When acceptance and a new grant occur in the same cycle, the new word SHALL replace the old with no bubble and no loss.

Reset
REQ-030 Asserting rst_n=0 SHALL, asynchronously, force y=0, s=0, y_valid=0, and ptr=0.
REQ-031 While rst_n=0, all ack bits SHALL be 0.
REQ-032 A reset asserted mid-transfer SHALL discard the held word, and no ack SHALL be issued until the first rising edge after rst_n returns to 1.
REQ-033 After reset, the first grant SHALL search from channel 0.

Verification
REQ-034 With N=4, W=1, en=1, o_ready=1, v=4'b1111, i=4'b1010, the bench SHALL see ack sequence 0001,0010,0100,1000,0001, s sequence 0,1,2,3,0 one cycle later, and y sequence 0,1,0,1.
REQ-035 With ptr=2 and v=4'b0011, the bench SHALL see ack=0001, then s=0, then ptr=1.
REQ-036 With y_valid=1, o_ready=0 for 3 cycles, and v=4'b1111, the bench SHALL see ack=0000 and y/s stable for those cycles; after o_ready rises, the next word SHALL appear one cycle later.
REQ-037 With en=0 and v=4'b1111 for 4 cycles, the bench SHALL see ack=0000, y_valid fall after one accept, and the held word drain once.
REQ-038 With rst_n pulsed low mid-stream, the bench SHALL see y=0, s=0, y_valid=0 immediately; after release with v=4'b1000, it SHALL see ack=1000 and s=3 on the next cycle.
REQ-039 With v=4'b0000 for 5 cycles, the bench SHALL see ack=0000, y_valid=0, and ptr unchanged.
